iic_cmd_seq: RTL and testbench
==============================

IIC_CMD_SEQ -- requirements
Module: iic_cmd_seq

Interface
REQ-001 Parameter: TIMEOUT, default 4096; maximum status-poll reads per command before abort.
REQ-002 Parameter: CR_INIT, default 32'h0000_0001; control-register enable value written after TX FIFO reset.
REQ-003 The module SHALL have one clock and an asynchronous active-high reset, with ports as follows:
- clk  in  1  rising-edge clock; also drives the IIC core s_axi_aclk.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_rd  in  1  1 = single-byte read, 0 = single-byte write.
- cmd_dev  in  7  I2C device address.
- cmd_wdata  in  8  write byte.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  1  AXI error or timeout, qualified by rsp_valid.
- rsp_rdata  out  8  read byte, qualified by rsp_valid; 0 for writes.
- m_awaddr  out  9  AXI-Lite master write address.
- m_awvalid  out  1  write address valid.
- m_awready  in  1  write address ready.
- m_wdata  out  32  write data.
- m_wstrb  out  4  write strobe.
- m_wvalid  out  1  write data valid.
- m_wready  in  1  write data ready.
- m_bresp  in  2  write response.
- m_bvalid  in  1  write response valid.
- m_bready  out  1  write response ready.
- m_araddr  out  9  AXI-Lite master read address.
- m_arvalid  out  1  read address valid.
- m_arready  in  1  read address ready.
- m_rdata  in  32  read data.
- m_rresp  in  2  read response.
- m_rvalid  in  1  read data valid.
- m_rready  out  1  read data ready.

Function
REQ-004 States: IDLE, CR_RST, CR_EN, TX_ADDR, TX_DATA, POLL, RX_READ, DONE; exactly one AXI transaction is outstanding at a time.
REQ-005 IDLE: cmd_ready=1. On handshake, the module SHALL capture cmd_rd, cmd_dev and cmd_wdata, clear the poll counter, and go to CR_RST.
REQ-006 Write transaction rules:
- m_awvalid and m_wvalid rise in the same cycle.
- Each is held until its own ready is sampled high, independently.
- m_wstrb = 4'hF.
- m_bready = 1 from address issue until m_bvalid.
- The next state is entered in the cycle after m_bvalid.
REQ-007 Read transaction rules:
- m_arvalid is held until m_arready.
- m_rready = 1 until m_rvalid.
- Stored m_rdata and m_rresp are evaluated in the cycle after m_rvalid.
REQ-008 Register sequence (address/data):
- CR_RST: 0x100 / 0x2.
- CR_EN: 0x100 / CR_INIT.
- TX_ADDR: 0x108 / {22'b0, 2'b01, cmd_dev, cmd_rd}.
- TX_DATA: 0x108 / {22'b0, 2'b10, cmd_rd ? 8'h01 : cmd_wdata}.
- POLL: read 0x104.
- RX_READ: read 0x10C.
REQ-009 POLL exit conditions:
- Write command: exit when SR[2]=0 (bus not busy) and SR[7]=1 (TX FIFO empty).
- Read command: exit when SR[6]=0 (RX FIFO not empty).
- Otherwise re-issue POLL with no idle cycle.
REQ-010 The poll counter SHALL increment per completed POLL read; when it reaches TIMEOUT without exit, the module SHALL go to DONE with rsp_err=1.
REQ-011 Any m_bresp or m_rresp != 2'b00 SHALL abort to DONE with rsp_err=1; no further AXI traffic is issued for that command.
REQ-012 After a successful POLL, a write command SHALL go to DONE; a read command SHALL go to RX_READ, then DONE with rsp_rdata = m_rdata[7:0].
REQ-013 DONE SHALL assert rsp_valid for one cycle and return to IDLE; cmd_ready=0 in all states except IDLE, so a cmd_valid arriving in DONE is accepted in the following cycle.
REQ-014 All AXI valid outputs, rsp_valid and rsp_err SHALL be registered.
REQ-015 Address, data and valid outputs SHALL be stable while valid is high and ready is low.

Reset
REQ-016 rst SHALL asynchronously force IDLE and drive:
- m_*valid = 0, m_bready = 0, m_rready = 0.
- m_awaddr = 0, m_araddr = 0, m_wdata = 0, m_wstrb = 0.
- rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
- cmd_ready = 0 while rst is high, 1 in the first cycle after release.
REQ-017 rst asserted mid-transaction SHALL drop all valids immediately; the in-flight command is discarded with no response.

Verification
REQ-018 Write cmd_dev=0x50, cmd_wdata=0xA5, slave ready immediately, SR=0x80 -> AXI writes 0x100/0x2, 0x100/0x1, 0x108/0x1A0, 0x108/0x2A5, one read of 0x104, then rsp_valid with rsp_err=0.
REQ-019 Read cmd_dev=0x50; SR returns 0x40 twice, then 0x00; RX_FIFO returns 0x3C -> TX writes 0x1A1 and 0x201; three POLL reads; read of 0x10C; rsp_rdata=0x3C, rsp_err=0.
REQ-020 m_awready delayed 3 cycles and m_wready delayed 1 cycle on CR_EN -> each valid held exactly until its own ready; only one B handshake occurs.
REQ-021 m_bresp=2'b10 on TX_ADDR -> no further AXI transactions; rsp_valid with rsp_err=1.
REQ-022 TIMEOUT=8 and SR stuck at 0x04 on a write -> exactly 8 POLL reads, then rsp_err=1.
REQ-023 rst pulsed while m_arvalid=1 during POLL -> m_arvalid=0 in the same cycle; no rsp_valid; a new command is accepted after release.

Source files
------------

// File: rtl/iic_cmd_seq.sv
// Single-byte I2C command sequencer driving an AXI IIC core over AXI-Lite.
// Each command runs: TX FIFO reset, enable, address byte, data byte, status poll, optional RX read.
module iic_cmd_seq #(
    parameter int unsigned TIMEOUT = 4096,
    parameter logic [31:0] CR_INIT = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rd,
    input  logic [6:0]  cmd_dev,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [7:0]  rsp_rdata,
    output logic [8:0]  m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [8:0]  m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [8:0] A_CR = 9'h100;
    localparam logic [8:0] A_SR = 9'h104;
    localparam logic [8:0] A_TX = 9'h108;
    localparam logic [8:0] A_RX = 9'h10C;

    typedef enum logic [2:0] {
        S_IDLE, S_CR_RST, S_CR_EN, S_TX_ADDR, S_TX_DATA, S_POLL, S_RX_READ, S_DONE
    } state_t;

    state_t        r_state, w_state;
    logic          r_awvalid, w_awvalid, r_wvalid, w_wvalid, r_bready, w_bready;
    logic          r_arvalid, w_arvalid, r_rready, w_rready;
    logic [8:0]    r_awaddr, w_awaddr, r_araddr, w_araddr;
    logic [31:0]   r_wdata, w_wdata;
    logic [3:0]    r_wstrb, w_wstrb;
    logic          r_rsp_valid, w_rsp_valid, r_rsp_err, w_rsp_err;
    logic [7:0]    r_rsp_rdata, w_rsp_rdata;
    logic          r_cmd_rd, w_cmd_rd;
    logic [6:0]    r_cmd_dev, w_cmd_dev;
    logic [7:0]    r_cmd_wdata, w_cmd_wdata;
    logic [CW-1:0] r_poll_cnt, w_poll_cnt;
    logic          r_eval, w_eval, r_rerr_s, w_rerr_s;
    logic [7:0]    r_rdata_s, w_rdata_s;

    logic          w_wr_go, w_rd_go, w_fail, w_finish, w_b_ok, w_b_err, w_sr_ok, w_r_hs;
    logic [8:0]    w_wr_addr, w_rd_addr;
    logic [31:0]   w_wr_data;
    logic          w_unused;

    assign w_unused = ^m_rdata[31:8];

    // Next-state and next-output logic; each transaction is launched on the edge that enters its state
    always_comb begin
        w_state     = r_state;
        w_awvalid   = r_awvalid & ~m_awready;
        w_wvalid    = r_wvalid & ~m_wready;
        w_bready    = r_bready & ~m_bvalid;
        w_arvalid   = r_arvalid & ~m_arready;
        w_rready    = r_rready & ~m_rvalid;
        w_awaddr    = r_awaddr;
        w_wdata     = r_wdata;
        w_wstrb     = r_wstrb;
        w_araddr    = r_araddr;
        w_rsp_valid = 1'b0;
        w_rsp_err   = r_rsp_err;
        w_rsp_rdata = r_rsp_rdata;
        w_cmd_rd    = r_cmd_rd;
        w_cmd_dev   = r_cmd_dev;
        w_cmd_wdata = r_cmd_wdata;
        w_poll_cnt  = r_poll_cnt;
        w_r_hs      = r_rready & m_rvalid;
        w_eval      = w_r_hs;
        w_rdata_s   = w_r_hs ? m_rdata[7:0] : r_rdata_s;
        w_rerr_s    = w_r_hs ? (m_rresp != 2'b00) : r_rerr_s;
        w_wr_go     = 1'b0;
        w_wr_addr   = A_CR;
        w_wr_data   = 32'h0;
        w_rd_go     = 1'b0;
        w_rd_addr   = A_SR;
        w_fail      = 1'b0;
        w_finish    = 1'b0;
        w_b_ok      = r_bready & m_bvalid & (m_bresp == 2'b00);
        w_b_err     = r_bready & m_bvalid & (m_bresp != 2'b00);
        w_sr_ok     = r_cmd_rd ? ~r_rdata_s[6] : (~r_rdata_s[2] & r_rdata_s[7]);

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_cmd_rd    = cmd_rd;
                    w_cmd_dev   = cmd_dev;
                    w_cmd_wdata = cmd_wdata;
                    w_poll_cnt  = '0;
                    w_state     = S_CR_RST;
                    w_wr_go     = 1'b1;
                    w_wr_addr   = A_CR;
                    w_wr_data   = 32'h0000_0002;
                end
            end
            S_CR_RST: begin
                if (w_b_err) begin
                    w_fail = 1'b1;
                end else if (w_b_ok) begin
                    w_state   = S_CR_EN;
                    w_wr_go   = 1'b1;
                    w_wr_addr = A_CR;
                    w_wr_data = CR_INIT;
                end
            end
            S_CR_EN: begin
                if (w_b_err) begin
                    w_fail = 1'b1;
                end else if (w_b_ok) begin
                    w_state   = S_TX_ADDR;
                    w_wr_go   = 1'b1;
                    w_wr_addr = A_TX;
                    w_wr_data = {22'b0, 2'b01, r_cmd_dev, r_cmd_rd};
                end
            end
            S_TX_ADDR: begin
                if (w_b_err) begin
                    w_fail = 1'b1;
                end else if (w_b_ok) begin
                    w_state   = S_TX_DATA;
                    w_wr_go   = 1'b1;
                    w_wr_addr = A_TX;
                    w_wr_data = {22'b0, 2'b10, (r_cmd_rd ? 8'h01 : r_cmd_wdata)};
                end
            end
            S_TX_DATA: begin
                if (w_b_err) begin
                    w_fail = 1'b1;
                end else if (w_b_ok) begin
                    w_state   = S_POLL;
                    w_rd_go   = 1'b1;
                    w_rd_addr = A_SR;
                end
            end
            S_POLL: begin
                // Status is judged one cycle after the R beat, from the captured copy
                if (r_eval) begin
                    w_poll_cnt = r_poll_cnt + CW'(1);
                    if (r_rerr_s) begin
                        w_fail = 1'b1;
                    end else if (w_sr_ok) begin
                        if (r_cmd_rd) begin
                            w_state   = S_RX_READ;
                            w_rd_go   = 1'b1;
                            w_rd_addr = A_RX;
                        end else begin
                            w_finish = 1'b1;
                        end
                    end else if (32'(w_poll_cnt) >= TIMEOUT) begin
                        w_fail = 1'b1;
                    end else begin
                        w_rd_go   = 1'b1;
                        w_rd_addr = A_SR;
                    end
                end
            end
            S_RX_READ: begin
                if (r_eval) begin
                    if (r_rerr_s) begin
                        w_fail = 1'b1;
                    end else begin
                        w_finish = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        if (w_wr_go) begin
            w_awvalid = 1'b1;
            w_wvalid  = 1'b1;
            w_bready  = 1'b1;
            w_awaddr  = w_wr_addr;
            w_wdata   = w_wr_data;
            w_wstrb   = 4'hF;
        end
        if (w_rd_go) begin
            w_arvalid = 1'b1;
            w_rready  = 1'b1;
            w_araddr  = w_rd_addr;
        end
        if (w_fail) begin
            w_state     = S_DONE;
            w_rsp_valid = 1'b1;
            w_rsp_err   = 1'b1;
            w_rsp_rdata = 8'h00;
        end
        if (w_finish) begin
            w_state     = S_DONE;
            w_rsp_valid = 1'b1;
            w_rsp_err   = 1'b0;
            w_rsp_rdata = r_cmd_rd ? r_rdata_s : 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_araddr    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_cmd_rd    <= 1'b0;
            r_cmd_dev   <= '0;
            r_cmd_wdata <= '0;
            r_poll_cnt  <= '0;
            r_eval      <= 1'b0;
            r_rerr_s    <= 1'b0;
            r_rdata_s   <= '0;
        end else begin
            r_state     <= w_state;
            r_awvalid   <= w_awvalid;
            r_wvalid    <= w_wvalid;
            r_bready    <= w_bready;
            r_arvalid   <= w_arvalid;
            r_rready    <= w_rready;
            r_awaddr    <= w_awaddr;
            r_wdata     <= w_wdata;
            r_wstrb     <= w_wstrb;
            r_araddr    <= w_araddr;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_err   <= w_rsp_err;
            r_rsp_rdata <= w_rsp_rdata;
            r_cmd_rd    <= w_cmd_rd;
            r_cmd_dev   <= w_cmd_dev;
            r_cmd_wdata <= w_cmd_wdata;
            r_poll_cnt  <= w_poll_cnt;
            r_eval      <= w_eval;
            r_rerr_s    <= w_rerr_s;
            r_rdata_s   <= w_rdata_s;
        end
    end

    // Ready only in IDLE and never while reset is held
    assign cmd_ready = (r_state == S_IDLE) & ~rst;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign m_awaddr  = r_awaddr;
    assign m_awvalid = r_awvalid;
    assign m_wdata   = r_wdata;
    assign m_wstrb   = r_wstrb;
    assign m_wvalid  = r_wvalid;
    assign m_bready  = r_bready;
    assign m_araddr  = r_araddr;
    assign m_arvalid = r_arvalid;
    assign m_rready  = r_rready;

endmodule

// File: tb/tb_iic_cmd_seq.sv
// Directed bench for iic_cmd_seq: scripted AXI-Lite slave plus a table of commands with expected traffic.
module tb_iic_cmd_seq;

    localparam int unsigned TO = 8;
    localparam int NV = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_rd;
    logic [6:0]  cmd_dev;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid, rsp_err;
    logic [7:0]  rsp_rdata;
    logic [8:0]  m_awaddr, m_araddr;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;

    iic_cmd_seq #(.TIMEOUT(TO), .CR_INIT(32'h0000_0001)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
        .cmd_dev(cmd_dev), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave scripting and traffic logs
    logic [31:0] sr_q[$];
    logic [7:0]  rx_byte;
    int          dly_idx, aw_dly, w_dly, berr_idx;
    logic [8:0]  wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [8:0]  rd_addr_log[$];
    int          aw_hi_log[$];
    int          w_hi_log[$];
    int          b_cnt, stab_err;
    bit          aw_done, w_done, ar_done;
    int          aw_hi, w_hi;
    logic [8:0]  aw_first;
    logic [31:0] w_first;

    // AXI-Lite slave: decides at each falling edge, handshakes complete on the next rising edge
    initial begin
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        aw_done = 0; w_done = 0; ar_done = 0; aw_hi = 0; w_hi = 0;
        aw_first = 0; w_first = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
                m_arready = 0; m_rvalid = 0; m_rresp = 0;
                aw_done = 0; w_done = 0; ar_done = 0; aw_hi = 0; w_hi = 0;
            end else begin
                if (m_bvalid) begin
                    m_bvalid = 0; m_bresp = 0; aw_done = 0; w_done = 0;
                end else if (aw_done && w_done) begin
                    if (!m_bready) stab_err++;
                    m_bvalid = 1;
                    m_bresp  = (b_cnt == berr_idx) ? 2'b10 : 2'b00;
                    b_cnt++;
                end
                m_awready = 0;
                if (m_awvalid && aw_done) stab_err++;
                if (m_awvalid && !aw_done) begin
                    if (aw_hi == 0) aw_first = m_awaddr;
                    else if (m_awaddr !== aw_first) stab_err++;
                    aw_hi++;
                    if (aw_hi > ((wr_addr_log.size() == dly_idx) ? aw_dly : 0)) begin
                        m_awready = 1; aw_done = 1;
                        wr_addr_log.push_back(m_awaddr); aw_hi_log.push_back(aw_hi); aw_hi = 0;
                    end
                end
                m_wready = 0;
                if (m_wvalid && w_done) stab_err++;
                if (m_wvalid && !w_done) begin
                    if (w_hi == 0) w_first = m_wdata;
                    else if (m_wdata !== w_first) stab_err++;
                    if (m_wstrb !== 4'hF) stab_err++;
                    w_hi++;
                    if (w_hi > ((wr_data_log.size() == dly_idx) ? w_dly : 0)) begin
                        m_wready = 1; w_done = 1;
                        wr_data_log.push_back(m_wdata); w_hi_log.push_back(w_hi); w_hi = 0;
                    end
                end
                if (m_rvalid) begin
                    m_rvalid = 0; ar_done = 0;
                end else if (ar_done) begin
                    if (!m_rready) stab_err++;
                    m_rvalid = 1; m_rresp = 0;
                    if (rd_addr_log[rd_addr_log.size()-1] == 9'h104) begin
                        m_rdata = sr_q[0];
                        if (sr_q.size() > 1) void'(sr_q.pop_front());
                    end else begin
                        m_rdata = {24'hABCDEF, rx_byte};
                    end
                end
                m_arready = 0;
                if (m_arvalid && ar_done) stab_err++;
                if (m_arvalid && !ar_done) begin
                    m_arready = 1; ar_done = 1; rd_addr_log.push_back(m_araddr);
                end
            end
        end
    end

    typedef struct {
        logic        rd;
        logic [6:0]  dev;
        logic [7:0]  wdata;
        logic [31:0] sr0, sr1, sr2;
        int          nsr;
        logic [7:0]  rx;
        int          dly_idx, aw_d, w_d, berr_idx;
        logic        exp_err;
        logic [7:0]  exp_rdata;
        int          exp_nwr, exp_npoll;
        logic [31:0] exp_txa, exp_txd;
    } vec_t;

    function automatic vec_t mkv(input logic rd, input logic [6:0] dev, input logic [7:0] wd,
                                 input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                                 input int nsr, input logic [7:0] rx, input int di, input int awd,
                                 input int wdd, input int be, input logic ee, input logic [7:0] erd,
                                 input int enw, input int enp, input logic [31:0] ta, input logic [31:0] td);
        vec_t v;
        v.rd = rd; v.dev = dev; v.wdata = wd; v.sr0 = s0; v.sr1 = s1; v.sr2 = s2; v.nsr = nsr;
        v.rx = rx; v.dly_idx = di; v.aw_d = awd; v.w_d = wdd; v.berr_idx = be;
        v.exp_err = ee; v.exp_rdata = erd; v.exp_nwr = enw; v.exp_npoll = enp;
        v.exp_txa = ta; v.exp_txd = td;
        return v;
    endfunction

    task automatic setup_slave(input vec_t v);
        sr_q.delete(); wr_addr_log.delete(); wr_data_log.delete(); rd_addr_log.delete();
        aw_hi_log.delete(); w_hi_log.delete();
        sr_q.push_back(v.sr0);
        if (v.nsr > 1) sr_q.push_back(v.sr1);
        if (v.nsr > 2) sr_q.push_back(v.sr2);
        rx_byte = v.rx; dly_idx = v.dly_idx; aw_dly = v.aw_d; w_dly = v.w_d; berr_idx = v.berr_idx;
        b_cnt = 0; stab_err = 0;
    endtask

    task automatic send_cmd(input logic rd, input logic [6:0] dev, input logic [7:0] wd);
        int n;
        @(negedge clk);
        cmd_rd = rd; cmd_dev = dev; cmd_wdata = wd; cmd_valid = 1;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(output bit got, output logic err, output logic [7:0] rd);
        int n;
        got = 0; err = 0; rd = 0; n = 0;
        while (!got && n < 3000) begin
            if (rsp_valid) begin got = 1; err = rsp_err; rd = rsp_rdata; end
            else begin @(negedge clk); n++; end
        end
    endtask

    vec_t vecs[NV];

    initial begin
        vec_t        v;
        bit          got;
        logic        err;
        logic [7:0]  rdata;
        logic [31:0] exp_wd;
        int          nrd_exp, n;
        bit          seen;

        vecs[0] = mkv(0, 7'h50, 8'hA5, 32'h80, 0, 0, 1, 8'h00, -1, 0, 0, -1, 0, 8'h00, 4, 1, 32'h1A0, 32'h2A5);
        vecs[1] = mkv(1, 7'h50, 8'h00, 32'h40, 32'h40, 32'h00, 3, 8'h3C, -1, 0, 0, -1, 0, 8'h3C, 4, 3, 32'h1A1, 32'h201);
        vecs[2] = mkv(0, 7'h7F, 8'h00, 32'h84, 32'h00, 32'hC0, 3, 8'h00, -1, 0, 0, -1, 0, 8'h00, 4, 3, 32'h1FE, 32'h200);
        vecs[3] = mkv(1, 7'h01, 8'h5A, 32'hFF, 32'hBF, 0, 2, 8'hE7, -1, 0, 0, -1, 0, 8'hE7, 4, 2, 32'h103, 32'h201);
        vecs[4] = mkv(0, 7'h50, 8'hA5, 32'h80, 0, 0, 1, 8'h00, 1, 3, 1, -1, 0, 8'h00, 4, 1, 32'h1A0, 32'h2A5);
        vecs[5] = mkv(0, 7'h50, 8'hA5, 32'h80, 0, 0, 1, 8'h00, -1, 0, 0, 2, 1, 8'h00, 3, 0, 32'h1A0, 32'h2A5);
        vecs[6] = mkv(0, 7'h12, 8'h34, 32'h04, 0, 0, 1, 8'h00, -1, 0, 0, -1, 1, 8'h00, 4, 8, 32'h124, 32'h234);
        vecs[7] = mkv(1, 7'h2B, 8'h00, 32'h40, 0, 0, 1, 8'h00, -1, 0, 0, -1, 1, 8'h00, 4, 8, 32'h157, 32'h201);

        rst = 1; cmd_valid = 0; cmd_rd = 0; cmd_dev = 0; cmd_wdata = 0;
        dly_idx = -1; aw_dly = 0; w_dly = 0; berr_idx = -1; rx_byte = 0; b_cnt = 0; stab_err = 0;
        #1;
        chk("reset_valids", 32'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 32'h0);
        chk("reset_addrs", 32'({m_awaddr, m_araddr, m_wstrb}), 32'h0);
        chk("reset_wdata", m_wdata, 32'h0);
        chk("reset_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'h0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'h0);
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        chk("release_cmd_ready", 32'(cmd_ready), 32'h1);

        for (int k = 0; k < NV; k++) begin
            v = vecs[k];
            setup_slave(v);
            send_cmd(v.rd, v.dev, v.wdata);
            wait_rsp(got, err, rdata);
            chk($sformatf("v%0d_rsp_seen", k), 32'(got), 32'h1);
            chk($sformatf("v%0d_busy_in_done", k), 32'(cmd_ready), 32'h0);
            chk($sformatf("v%0d_rsp_err", k), 32'(err), 32'(v.exp_err));
            if (!v.exp_err) chk($sformatf("v%0d_rsp_rdata", k), 32'(rdata), 32'(v.exp_rdata));
            @(negedge clk);
            chk($sformatf("v%0d_rsp_one_cycle", k), 32'(rsp_valid), 32'h0);
            chk($sformatf("v%0d_idle_ready", k), 32'(cmd_ready), 32'h1);
            chk($sformatf("v%0d_n_aw", k), 32'(wr_addr_log.size()), 32'(v.exp_nwr));
            chk($sformatf("v%0d_n_w", k), 32'(wr_data_log.size()), 32'(v.exp_nwr));
            chk($sformatf("v%0d_n_b", k), 32'(b_cnt), 32'(v.exp_nwr));
            for (int i = 0; i < wr_addr_log.size() && i < wr_data_log.size() && i < 4; i++) begin
                case (i)
                    0: exp_wd = 32'h2;
                    1: exp_wd = 32'h1;
                    2: exp_wd = v.exp_txa;
                    default: exp_wd = v.exp_txd;
                endcase
                chk($sformatf("v%0d_wr%0d_addr", k, i), 32'(wr_addr_log[i]), (i < 2) ? 32'h100 : 32'h108);
                chk($sformatf("v%0d_wr%0d_data", k, i), wr_data_log[i], exp_wd);
                chk($sformatf("v%0d_wr%0d_aw_hold", k, i), 32'(aw_hi_log[i]), 32'(((i == v.dly_idx) ? v.aw_d : 0) + 1));
                chk($sformatf("v%0d_wr%0d_w_hold", k, i), 32'(w_hi_log[i]), 32'(((i == v.dly_idx) ? v.w_d : 0) + 1));
            end
            nrd_exp = v.exp_npoll + ((v.rd && !v.exp_err) ? 1 : 0);
            chk($sformatf("v%0d_n_rd", k), 32'(rd_addr_log.size()), 32'(nrd_exp));
            for (int i = 0; i < rd_addr_log.size(); i++)
                chk($sformatf("v%0d_rd%0d_addr", k, i), 32'(rd_addr_log[i]), (i < v.exp_npoll) ? 32'h104 : 32'h10C);
            chk($sformatf("v%0d_protocol", k), 32'(stab_err), 32'h0);
        end

        // Command presented while DONE is accepted on the following IDLE cycle
        setup_slave(vecs[0]);
        send_cmd(1'b0, 7'h50, 8'hA5);
        wait_rsp(got, err, rdata);
        chk("b2b_first_rsp", 32'({got, err}), 32'h2);
        cmd_rd = 0; cmd_dev = 7'h33; cmd_wdata = 8'h77; cmd_valid = 1;
        @(negedge clk);
        chk("b2b_idle_ready", 32'(cmd_ready), 32'h1);
        @(negedge clk);
        cmd_valid = 0;
        chk("b2b_accepted", 32'({cmd_ready, m_awvalid}), 32'h1);
        chk("b2b_first_addr", 32'(m_awaddr), 32'h100);
        wait_rsp(got, err, rdata);
        chk("b2b_second_rsp", 32'({got, err}), 32'h2);
        chk("b2b_tx_addr", wr_data_log[wr_data_log.size()-2], 32'h166);
        chk("b2b_tx_data", wr_data_log[wr_data_log.size()-1], 32'h277);
        @(negedge clk);

        // Reset while a status-poll read address is outstanding
        setup_slave(vecs[6]);
        send_cmd(1'b0, 7'h12, 8'h34);
        n = 0;
        while (!m_arvalid && n < 200) begin @(negedge clk); n++; end
        chk("rst_reach_poll", 32'({m_arvalid, m_araddr}), 32'h304);
        rst = 1;
        #1;
        chk("rst_arvalid_drop", 32'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}), 32'h0);
        chk("rst_busy", 32'({cmd_ready, rsp_valid}), 32'h0);
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        chk("rst_release_ready", 32'(cmd_ready), 32'h1);
        seen = 0;
        repeat (8) begin @(negedge clk); seen |= rsp_valid; end
        chk("rst_no_rsp", 32'(seen), 32'h0);
        setup_slave(vecs[0]);
        send_cmd(1'b0, 7'h50, 8'hA5);
        wait_rsp(got, err, rdata);
        chk("rst_new_cmd_rsp", 32'({got, err}), 32'h2);
        chk("rst_new_cmd_n_w", 32'(wr_data_log.size()), 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
